// File: rtl/hyperbus_req_arbiter_pkg.sv
// Shared types and constant helpers for the hyperbus request arbiter.
package hyperbus_req_arbiter_pkg;

  // One-hot FSM encoding.
  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StIssue  = 4'b0010,
    StRdWait = 4'b0100,
    StWrWait = 4'b1000
  } state_e;

  typedef enum logic {
    CmdRead  = 1'b0,
    CmdWrite = 1'b1
  } cmd_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter that must be able to hold cnt_max.
  function automatic int unsigned cnt_width(input int unsigned cnt_max);
    return (cnt_max < 32'd1) ? 32'd1 : $clog2(cnt_max + 32'd1);
  endfunction

endpackage

// File: rtl/hyperbus_req_arbiter_if.sv
// Requester-side and hyperbus_fifo-side signals of the arbiter, bundled.
interface hyperbus_req_arbiter_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned IdW = $clog2(NREQ);

  // Requester side
  logic [NREQ-1:0]            req_rrq;
  logic [NREQ-1:0]            req_wrq;
  logic [NREQ*ADDR_WIDTH-1:0] req_adr;
  logic [NREQ*DATA_WIDTH-1:0] req_dat;
  logic [NREQ-1:0]            req_ack;
  logic [NREQ-1:0]            req_done;
  logic [NREQ-1:0]            req_err;
  logic [DATA_WIDTH-1:0]      rdat;
  logic                       busy;
  logic [IdW-1:0]             grant_id;
  logic                       stray_rx;

  // hyperbus_fifo side
  logic                       fifo_rrq;
  logic                       fifo_wrq;
  logic [ADDR_WIDTH-1:0]      fifo_adr;
  logic [DATA_WIDTH-1:0]      fifo_tx_dat;
  logic                       fifo_tx_ready;
  logic [DATA_WIDTH-1:0]      fifo_rx_dat;
  logic                       fifo_rx_valid;

  // Arbiter view
  modport master (
    input  req_rrq, req_wrq, req_adr, req_dat,
    input  fifo_tx_ready, fifo_rx_dat, fifo_rx_valid,
    output req_ack, req_done, req_err, rdat, busy, grant_id, stray_rx,
    output fifo_rrq, fifo_wrq, fifo_adr, fifo_tx_dat
  );

  // Environment view (requesters plus FIFO)
  modport slave (
    output req_rrq, req_wrq, req_adr, req_dat,
    output fifo_tx_ready, fifo_rx_dat, fifo_rx_valid,
    input  req_ack, req_done, req_err, rdat, busy, grant_id, stray_rx,
    input  fifo_rrq, fifo_wrq, fifo_adr, fifo_tx_dat
  );

endinterface

// File: rtl/hyperbus_req_arbiter_rr_arb.sv
// Combinational round-robin picker: first active request at or after i_ptr, wrapping.
module hyperbus_req_arbiter_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IdW-1:0]  i_ptr,
  output logic            o_valid,
  output logic [IdW-1:0]  o_idx
);

  int unsigned    w_pos;
  logic [IdW-1:0] w_cand;

  // Walk the ring starting at i_ptr; the first hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_pos  = (32'(i_ptr) + 32'(k)) % NREQ;
      w_cand = w_pos[IdW-1:0];
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/hyperbus_req_arbiter.sv
// Round-robin sequencer sharing one hyperbus_fifo user port among NREQ requesters.
// One transaction outstanding at a time; reports done/timeout back per requester.
module hyperbus_req_arbiter
  import hyperbus_req_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WR_GUARD   = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  hyperbus_req_arbiter_if.master bus
);

  localparam int unsigned IdW     = $clog2(NREQ);
  // The counter must reach WR_GUARD even when the timeout is disabled.
  localparam int unsigned CntMaxU = max_u(TIMEOUT, WR_GUARD);
  localparam int unsigned CntW    = cnt_width(CntMaxU);
  localparam logic [CntW-1:0] CntMax   = CntW'(CntMaxU);
  localparam logic [CntW-1:0] CntGuard = CntW'(WR_GUARD);
  localparam logic [CntW-1:0] CntTmo   = CntW'(TIMEOUT);

  state_e                r_state, w_state_nxt;
  cmd_e                  r_op, w_op_nxt;
  logic [IdW-1:0]        r_ptr, w_ptr_nxt;
  logic [IdW-1:0]        r_gid, w_gid_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_adr, w_adr_nxt;
  logic [DATA_WIDTH-1:0] r_txdat, w_txdat_nxt;
  logic [DATA_WIDTH-1:0] r_rdat, w_rdat_nxt;
  logic [NREQ-1:0]       r_done, w_done_nxt;
  logic [NREQ-1:0]       r_err, w_err_nxt;
  logic                  r_stray, w_stray_nxt;

  logic [NREQ-1:0]       w_active;
  logic                  w_pick_vld;
  logic [IdW-1:0]        w_pick_idx;
  logic [CntW-1:0]       w_cnt_inc;
  logic                  w_timeout;
  logic [NREQ-1:0]       w_gid_oh;

  assign w_active  = bus.req_rrq | bus.req_wrq;
  assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntW'(1);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CntTmo);
  assign w_gid_oh  = NREQ'(1) << r_gid;

  hyperbus_req_arbiter_rr_arb #(
    .NREQ (NREQ),
    .IdW  (IdW)
  ) u_rr_arb (
    .i_req   (w_active),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_op    <= CmdRead;
      r_ptr   <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_txdat <= '0;
      r_rdat  <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_stray <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gid   <= w_gid_nxt;
      r_cnt   <= w_cnt_nxt;
      r_adr   <= w_adr_nxt;
      r_txdat <= w_txdat_nxt;
      r_rdat  <= w_rdat_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_stray <= w_stray_nxt;
    end
  end

  // Next-state logic: grant, issue, then wait for completion or expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_ptr_nxt   = r_ptr;
    w_gid_nxt   = r_gid;
    w_cnt_nxt   = w_cnt_inc;
    w_adr_nxt   = r_adr;
    w_txdat_nxt = r_txdat;
    w_rdat_nxt  = r_rdat;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_stray_nxt = r_stray;

    unique case (r_state)
      StIdle: begin
        // Zero while in ISSUE, so r_cnt equals cycles elapsed since ISSUE.
        w_cnt_nxt = '0;
        if (w_pick_vld && bus.fifo_tx_ready) begin
          w_state_nxt = StIssue;
          w_gid_nxt   = w_pick_idx;
          w_ptr_nxt   = (w_pick_idx == IdW'(NREQ - 1)) ? '0 : w_pick_idx + IdW'(1);
          w_op_nxt    = bus.req_rrq[w_pick_idx] ? CmdRead : CmdWrite;
          w_adr_nxt   = bus.req_adr[32'(w_pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
          w_txdat_nxt = bus.req_dat[32'(w_pick_idx) * DATA_WIDTH +: DATA_WIDTH];
        end
      end
      StIssue: begin
        w_state_nxt = (r_op == CmdRead) ? StRdWait : StWrWait;
      end
      StRdWait: begin
        // Completion takes priority over a simultaneous expiry.
        if (bus.fifo_rx_valid) begin
          w_rdat_nxt  = bus.fifo_rx_dat;
          w_done_nxt  = w_gid_oh;
          w_state_nxt = StIdle;
        end else if (w_timeout) begin
          w_err_nxt   = w_gid_oh;
          w_state_nxt = StIdle;
        end
      end
      StWrWait: begin
        // tx_ready lags the write through the CDC, so it is not trusted until the guard expires.
        if ((r_cnt >= CntGuard) && bus.fifo_tx_ready) begin
          w_done_nxt  = w_gid_oh;
          w_state_nxt = StIdle;
        end else if (w_timeout) begin
          w_err_nxt   = w_gid_oh;
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    if (bus.fifo_rx_valid && (r_state != StRdWait)) begin
      w_stray_nxt = 1'b1;
    end
  end

  assign bus.req_ack     = (r_state == StIssue) ? w_gid_oh : '0;
  assign bus.fifo_rrq    = (r_state == StIssue) && (r_op == CmdRead);
  assign bus.fifo_wrq    = (r_state == StIssue) && (r_op == CmdWrite);
  assign bus.fifo_adr    = r_adr;
  assign bus.fifo_tx_dat = r_txdat;
  assign bus.req_done    = r_done;
  assign bus.req_err     = r_err;
  assign bus.rdat        = r_rdat;
  assign bus.busy        = (r_state != StIdle);
  assign bus.grant_id    = r_gid;
  assign bus.stray_rx    = r_stray;

endmodule
